// File: rtl/bcd_pkg.sv
// Shared BCD definitions: the digit type, the decimal radix constant and the
// sequencer state encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [4:0] BCD_TEN  = 5'd10;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal carry (purely combinational).
// Ports:
//   a_d, b_d : operand digits (b_d is already nine's-complemented in sub mode)
//   c        : carry in
//   s_d      : result digit
//   c_out    : decimal carry out (sum >= 10)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       c,
  output bcd_digit_t s_d,
  output logic       c_out
);

  logic [4:0] w_t;

  assign w_t   = {1'b0, a_d} + {1'b0, b_d} + {4'd0, c};
  assign c_out = (w_t >= BCD_TEN);
  // Out-of-range digits simply wrap here; the result is garbage but repeatable.
  assign s_d   = c_out ? 4'(w_t - BCD_TEN) : w_t[3:0];

endmodule

// File: rtl/bcdadd_seq.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first.
// Optional operand digit check enabled by macro BCDADD_CHECK_EN.
// Ports:
//   clk, reset (async, active-low)
//   start, sub, a, b, cin : operation request, sampled in IDLE or DONE
//   s, cout               : registered result and carry / no-borrow flag
//   busy                  : high while digits are processed
//   done                  : one-cycle pulse when s/cout are final
//   invalid               : sticky bad-digit flag (0 when the check is absent)
module bcdadd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 cin,
  output logic [4*NDIGITS-1:0] s,
  output logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 invalid
);

  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  bcd_state_t      r_state, w_state_n;
  logic [W-1:0]    r_a, w_a_n;
  logic [W-1:0]    r_b, w_b_n;
  logic            r_sub, w_sub_n;
  logic            r_carry, w_carry_n;
  logic [IW-1:0]   r_idx, w_idx_n;
  logic [W-1:0]    r_s, w_s_n;
  logic            r_cout, w_cout_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;

  bcd_digit_t w_a_d, w_b_raw, w_b_d, w_s_d;
  logic       w_c_out;

  // Current digit; subtraction adds the nine's complement of b.
  assign w_a_d   = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_raw = r_b[{r_idx, 2'b00} +: 4];
  assign w_b_d   = r_sub ? 4'(BCD_NINE - w_b_raw) : w_b_raw;

  bcd_digit_add u_digit (
    .a_d   (w_a_d),
    .b_d   (w_b_d),
    .c     (r_carry),
    .s_d   (w_s_d),
    .c_out (w_c_out)
  );

`ifdef BCDADD_CHECK_EN
  logic r_invalid, w_invalid_n;
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_sub_n   = r_sub;
    w_carry_n = r_carry;
    w_idx_n   = r_idx;
    w_s_n     = r_s;
    w_cout_n  = r_cout;
    w_done_n  = 1'b0;
`ifdef BCDADD_CHECK_EN
    w_invalid_n = r_invalid;
`endif
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_n = RUN;
          w_a_n     = a;
          w_b_n     = b;
          w_sub_n   = sub;
          w_carry_n = sub ? ~cin : cin;
          w_idx_n   = '0;
          w_s_n     = '0;
          w_cout_n  = 1'b0;
`ifdef BCDADD_CHECK_EN
          w_invalid_n = 1'b0;
`endif
        end else begin
          w_state_n = IDLE;
        end
      end
      RUN: begin
        w_s_n[{r_idx, 2'b00} +: 4] = w_s_d;
        w_carry_n = w_c_out;
`ifdef BCDADD_CHECK_EN
        if ((w_a_d > BCD_NINE) || (w_b_raw > BCD_NINE)) w_invalid_n = 1'b1;
`endif
        if (r_idx == LAST_IDX) begin
          w_state_n = DONE;
          w_cout_n  = w_c_out;
          w_done_n  = 1'b1;
        end else begin
          w_idx_n = r_idx + IW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_busy_n = (w_state_n == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_sub   <= w_sub_n;
      r_carry <= w_carry_n;
      r_idx   <= w_idx_n;
      r_s     <= w_s_n;
      r_cout  <= w_cout_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

`ifdef BCDADD_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_invalid <= 1'b0;
    else        r_invalid <= w_invalid_n;
  end
  assign invalid = r_invalid;
`else
  assign invalid = 1'b0;
`endif

  assign s    = r_s;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bcdadd_seq.sv
// Self-checking bench for bcdadd_seq (NDIGITS=4 plus a NDIGITS=1 instance).
module tb_bcdadd_seq;

  localparam int unsigned ND = 4;
  localparam int unsigned W  = 4 * ND;

`ifdef BCDADD_CHECK_EN
  localparam logic EXP_INV = 1'b1;
`else
  localparam logic EXP_INV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start, sub, cin;
  logic [W-1:0] a, b, s;
  logic         cout, busy, done, invalid;

  logic         start1, sub1, cin1;
  logic [3:0]   a1, b1, s1;
  logic         cout1, busy1, done1, invalid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcdadd_seq #(.NDIGITS(ND)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .busy(busy), .done(done), .invalid(invalid)
  );

  bcdadd_seq #(.NDIGITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .busy(busy1), .done(done1), .invalid(invalid1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal integer arithmetic on the decoded operands.
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, output logic [W-1:0] es, output logic ec);
    longint m = 1;
    longint v;
    for (int i = 0; i < ND; i++) m = m * 10;
    if (!sb) begin
      v  = bcd2int(aa) + bcd2int(bb) + longint'(ci);
      ec = (v >= m);
      es = int2bcd(v % m);
    end else begin
      v  = bcd2int(aa) - bcd2int(bb) - longint'(ci);
      ec = (v >= 0);
      es = int2bcd((v >= 0) ? v : v + m);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat counts sampling
  // points from the accept edge, 0 means done never came.
  task automatic run_op(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic ci, output int lat, output logic [W-1:0] so,
                        output logic co, output logic inv, output logic bz);
    @(negedge clk);
    sub = sb; a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    so = s; co = cout; inv = invalid; bz = busy;
  endtask

  typedef struct {
    logic         sb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] so, es;
    logic co, inv, bz, ec;
    int done_seen;

    vecs[0] = '{1'b0, 16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{1'b0, 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1};
    vecs[3] = '{1'b1, 16'h1234, 16'h5000, 1'b0, 16'h6234, 1'b0};
    vecs[4] = '{1'b0, 16'h0001, 16'h0009, 1'b0, 16'h0010, 1'b0};
    vecs[5] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b0};
    vecs[6] = '{1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
    vecs[7] = '{1'b1, 16'h4321, 16'h4320, 1'b1, 16'h0000, 1'b1};

    start = 0; sub = 0; cin = 0; a = '0; b = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s", 64'(s), 0);
    chk("reset_cout", 64'(cout), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_invalid", 64'(invalid), 0);
    @(negedge clk) reset = 1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].sb, vecs[i].a, vecs[i].b, vecs[i].ci, lat, so, co, inv, bz);
      chk($sformatf("vec%0d_latency", i), 64'(lat), ND + 1);
      chk($sformatf("vec%0d_s", i), 64'(so), 64'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].ec));
      chk($sformatf("vec%0d_busy_at_done", i), 64'(bz), 0);
      chk($sformatf("vec%0d_invalid", i), 64'(inv), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_hold_s", i), 64'(s), 64'(vecs[i].es));
      chk($sformatf("vec%0d_hold_cout", i), 64'(cout), 64'(vecs[i].ec));
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 0);
    end

    // Start pulsed two cycles into RUN must be ignored
    @(negedge clk);
    sub = 1; a = 16'h5000; b = 16'h1234; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1; sub = 0; a = 16'h9999; b = 16'h9999; cin = 1;
      end else begin
        start = 0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 0;
    chk("ignore_latency", 64'(lat), ND + 1);
    chk("ignore_s", 64'(s), 64'h3766);
    chk("ignore_cout", 64'(cout), 1);
    @(negedge clk);
    chk("ignore_no_second_op", 64'(busy), 0);

    // Start held high through DONE: back-to-back operations
    @(negedge clk);
    sub = 0; a = 16'h1234; b = 16'h8766; cin = 0; start = 1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b_first_latency", 64'(lat), ND + 1);
    chk("b2b_first_s", 64'(s), 64'h0000);
    chk("b2b_first_cout", 64'(cout), 1);
    sub = 1; a = 16'h5000; b = 16'h1234; cin = 0;
    @(negedge clk);
    chk("b2b_no_idle_busy", 64'(busy), 1);
    chk("b2b_done_single", 64'(done), 0);
    start = 0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("b2b_second_latency", 64'(lat), ND + 1);
    chk("b2b_second_s", 64'(s), 64'h3766);
    chk("b2b_second_cout", 64'(cout), 1);

    // Reset in the middle of RUN
    @(negedge clk);
    sub = 0; a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 1);
    #2 reset = 0;
    #1;
    chk("abort_s", 64'(s), 0);
    chk("abort_cout", 64'(cout), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_invalid", 64'(invalid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 0);

    // NDIGITS=1 instance
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      sub1 = 0; a1 = (t == 0) ? 4'd5 : 4'd9; b1 = (t == 0) ? 4'd4 : 4'd9;
      cin1 = (t == 0) ? 1'b0 : 1'b1; start1 = 1;
      @(posedge clk);
      #1 start1 = 0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (done1) begin
          lat = k;
          break;
        end
      end
      chk($sformatf("nd1_%0d_latency", t), 64'(lat), 2);
      chk($sformatf("nd1_%0d_s", t), 64'(s1), 9);
      chk($sformatf("nd1_%0d_cout", t), 64'(cout1), (t == 0) ? 0 : 1);
    end

    // Invalid digit flag
    run_op(1'b0, 16'h00A0, 16'h0000, 1'b0, lat, so, co, inv, bz);
    chk("inv_latency", 64'(lat), ND + 1);
    chk("inv_flag", 64'(inv), 64'(EXP_INV));
    run_op(1'b0, 16'h0001, 16'h0001, 1'b0, lat, so, co, inv, bz);
    chk("inv_cleared", 64'(inv), 0);
    chk("inv_next_s", 64'(so), 64'h0002);

    // Random operations against the decimal model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs, rc;
      for (int d = 0; d < ND; d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(rs, ra, rb, rc, es, ec);
      run_op(rs, ra, rb, rc, lat, so, co, inv, bz);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), ND + 1);
      chk($sformatf("rnd%0d_s(%0h %s %0h c%0d)", i, ra, rs ? "-" : "+", rb, rc),
          64'(so), 64'(es));
      chk($sformatf("rnd%0d_cout", i), 64'(co), 64'(ec));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
